// File: rtl/matmul_seq.sv
// Term sequencer for the complex matrix multiply C = A*B: walks (i,j,k) with k innermost,
// drives the M1/M2 ROM addresses and emits MAC strobes and result-RAM writes aligned to the datapath.
module matmul_seq #(
  parameter int DIM    = 3,
  parameter int LAT    = 3,
  parameter int ADDR_W = $clog2(DIM*DIM*2-1),
  parameter int RES_W  = $clog2(DIM*DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic [ADDR_W-1:0] addr_am1,
  output logic [ADDR_W-1:0] addr_bm1,
  output logic [ADDR_W-1:0] addr_am2,
  output logic [ADDR_W-1:0] addr_bm2,
  output logic              mac_valid,
  output logic              mac_first,
  output logic              mac_last,
  output logic              res_we,
  output logic [RES_W-1:0]  res_addr,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CNT_W-1:0] KMAX     = CNT_W'(DIM-1);
  localparam logic [RES_W-1:0] RES_LAST = RES_W'(DIM*DIM-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [CNT_W-1:0]  i_nx, j_nx, k_nx;
  logic [CNT_W-1:0]  ti, tj, tk;
  logic              do_issue;
  logic              issue_v_q, issue_v_d;
  logic              issue_first_q, issue_first_d;
  logic              issue_last_q, issue_last_d;
  logic [ADDR_W-1:0] addr_am1_q, addr_am1_d, addr_bm1_q, addr_bm1_d;
  logic [ADDR_W-1:0] addr_am2_q, addr_am2_d, addr_bm2_q, addr_bm2_d;
  logic [LAT-1:0]    pipe_v_q, pipe_v_d, pipe_f_q, pipe_f_d, pipe_l_q, pipe_l_d;
  logic              res_we_q, res_we_d;
  logic [RES_W-1:0]  res_addr_q, res_addr_d;
  logic [RES_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  function automatic logic [ADDR_W-1:0] elem_addr(input logic [CNT_W-1:0] r,
                                                  input logic [CNT_W-1:0] c);
    return ADDR_W'(2 * (int'(r) * DIM + int'(c)));
  endfunction

  always_comb begin
    k_nx = (k_q == KMAX) ? '0 : k_q + CNT_W'(1);
    j_nx = j_q;
    i_nx = i_q;
    if (k_q == KMAX) begin
      j_nx = (j_q == KMAX) ? '0 : j_q + CNT_W'(1);
      if (j_q == KMAX)
        i_nx = (i_q == KMAX) ? '0 : i_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    busy_d        = busy_q;
    do_issue      = 1'b0;
    ti            = '0;
    tj            = '0;
    tk            = '0;
    issue_v_d     = 1'b0;
    issue_first_d = 1'b0;
    issue_last_d  = 1'b0;
    addr_am1_d    = addr_am1_q;
    addr_bm1_d    = addr_bm1_q;
    addr_am2_d    = addr_am2_q;
    addr_bm2_d    = addr_bm2_q;

    // Result side runs purely off the delayed MAC strobes.
    res_we_d   = pipe_v_q[LAT-1] & pipe_l_q[LAT-1];
    res_addr_d = res_we_d ? wr_cnt_q : res_addr_q;
    wr_cnt_d   = res_we_d ? wr_cnt_q + RES_W'(1) : wr_cnt_q;
    done_d     = res_we_d && (wr_cnt_q == RES_LAST);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          wr_cnt_d = '0;
          do_issue = 1'b1;
        end
      end
      RUN: begin
        if (!hold) begin
          do_issue = 1'b1;
          ti       = i_nx;
          tj       = j_nx;
          tk       = k_nx;
          if (i_nx == KMAX && j_nx == KMAX && k_nx == KMAX)
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (done_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_issue) begin
      i_d           = ti;
      j_d           = tj;
      k_d           = tk;
      issue_v_d     = 1'b1;
      issue_first_d = (tk == '0);
      issue_last_d  = (tk == KMAX);
      addr_am1_d    = elem_addr(ti, tk);
      addr_bm1_d    = elem_addr(ti, tk) + ADDR_W'(1);
      addr_am2_d    = elem_addr(tk, tj);
      addr_bm2_d    = elem_addr(tk, tj) + ADDR_W'(1);
    end

    // Alignment pipe to the sumtwo output; keeps shifting regardless of hold.
    pipe_v_d[0] = issue_v_q;
    pipe_f_d[0] = issue_first_q;
    pipe_l_d[0] = issue_last_q;
    for (int n = 1; n < LAT; n++) begin
      pipe_v_d[n] = pipe_v_q[n-1];
      pipe_f_d[n] = pipe_f_q[n-1];
      pipe_l_d[n] = pipe_l_q[n-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      issue_v_q     <= 1'b0;
      issue_first_q <= 1'b0;
      issue_last_q  <= 1'b0;
      addr_am1_q    <= '0;
      addr_bm1_q    <= '0;
      addr_am2_q    <= '0;
      addr_bm2_q    <= '0;
      pipe_v_q      <= '0;
      pipe_f_q      <= '0;
      pipe_l_q      <= '0;
      res_we_q      <= 1'b0;
      res_addr_q    <= '0;
      wr_cnt_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      k_q           <= k_d;
      issue_v_q     <= issue_v_d;
      issue_first_q <= issue_first_d;
      issue_last_q  <= issue_last_d;
      addr_am1_q    <= addr_am1_d;
      addr_bm1_q    <= addr_bm1_d;
      addr_am2_q    <= addr_am2_d;
      addr_bm2_q    <= addr_bm2_d;
      pipe_v_q      <= pipe_v_d;
      pipe_f_q      <= pipe_f_d;
      pipe_l_q      <= pipe_l_d;
      res_we_q      <= res_we_d;
      res_addr_q    <= res_addr_d;
      wr_cnt_q      <= wr_cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign addr_am1  = addr_am1_q;
  assign addr_bm1  = addr_bm1_q;
  assign addr_am2  = addr_am2_q;
  assign addr_bm2  = addr_bm2_q;
  assign mac_valid = pipe_v_q[LAT-1];
  assign mac_first = pipe_f_q[LAT-1];
  assign mac_last  = pipe_l_q[LAT-1];
  assign res_we    = res_we_q;
  assign res_addr  = res_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/matmul_seq.md
Name: matmul_seq

Overview:
- Sequencer for the complex matrix-multiply datapath: dual-port ROMs for M1/M2 (real/imag interleaved), then prodtwo, then sumtwo, then accumulator, then result SPRAMs.
- Computes C = A·B for DIM×DIM complex matrices by issuing one (i,j,k) term per cycle.
- Drives all four ROM addresses and produces term-valid/first/last strobes aligned to the sumtwo output.
- Produces a result write strobe and address for the result RAMs, and wraps the job in a start/busy/done handshake.

Parameters:
- DIM, 3, matrix dimension (≥2).
- LAT, 3, cycles from ROM address presented to valid ab_real/ab_imag (ROM 1 + prodtwo 1 + sumtwo 1).
- ADDR_W, $clog2(DIM*DIM*2-1), ROM address width (5 for DIM=3).
- RES_W, $clog2(DIM*DIM), result address width (4 for DIM=3).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled in IDLE only.
- hold  in  1  suppresses term issue while high (inserts bubbles).
- addr_am1  out  ADDR_W  M1 port A address (A real).
- addr_bm1  out  ADDR_W  M1 port B address (A imag).
- addr_am2  out  ADDR_W  M2 port A address (B real).
- addr_bm2  out  ADDR_W  M2 port B address (B imag).
- mac_valid  out  1  ab_real/ab_imag carry a valid term this cycle.
- mac_first  out  1  valid term is k=0 (accumulator clear-and-load).
- mac_last  out  1  valid term is k=DIM-1.
- res_we  out  1  accumulated C(i,j) ready; write result RAMs.
- res_addr  out  RES_W  i*DIM+j for the current res_we.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse on final result write.

Behaviour:
- Memory layout: element (r,c) real at 2*(r*DIM+c), imag at 2*(r*DIM+c)+1.
- For term (i,j,k): addr_am1=2*(i*DIM+k), addr_bm1=addr_am1+1, addr_am2=2*(k*DIM+j), addr_bm2=addr_am2+1.
- Issue order: k innermost, then j, then i; k, j and i each wrap DIM-1→0.
- Reset (rst=0, async):
  - state IDLE.
  - All address outputs 0.
  - mac_valid, mac_first, mac_last, res_we, busy, done all 0.
  - res_addr 0; counters and issue pipeline cleared.
  - Reset mid-job aborts the job with no further strobes.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN when start=1 at an edge. On that same edge, outputs present term (0,0,0) and issue_v=1.
  - RUN: on each edge with hold=0, advance to the next term. On an edge with hold=1, issue_v=0 for the next cycle and counters/addresses are frozen.
  - RUN→DRAIN on the edge that issues term (DIM-1,DIM-1,DIM-1).
  - DRAIN: no issue. Wait until the last term has propagated and res_we has fired, then return to IDLE.
- All outputs are registered.
- mac_valid/first/last = issue_v/first/last delayed exactly LAT cycles through a shift pipeline. This pipeline is independent of hold.
- res_we = mac_valid & mac_last delayed 1 cycle. res_addr is captured with it.
- done = res_we on the final element (res_addr = DIM*DIM-1). The cycle after done, busy=0 and state=IDLE.
- busy is 1 from the start edge through the done cycle, inclusive.
- start while busy is ignored. start and done coinciding does not launch a new job; start must be reasserted in IDLE.
- hold in IDLE or DRAIN has no effect.
- hold does not break accumulation: bubbles carry mac_valid=0, and the accumulator must only add when mac_valid=1.
- Addresses hold their last value when not issuing.

Test Plan:
1. Reset with start=1 held → all outputs 0, state IDLE. Release rst → busy=1 and addresses 0/1/0/1 after the first edge.
2. DIM=3, start pulse at edge T0, hold=0 → term sequence (am1,am2):
   - (0,0), (2,6), (4,12), then j=1: (0,2).
   - Last term (16,16) at T0+26.
   - mac_first at T0+3, mac_last at T0+5/T0+29.
   - res_we ×9 with res_addr 0..8; final res_we + done at T0+30; busy=0 after T0+31.
3. hold=1 for 2 cycles after the 5th term → addresses frozen, mac_valid low for exactly 2 cycles LAT later, done at T0+32, res_addr order unchanged.
4. start asserted at T0+10 during RUN and again in the done cycle → ignored, no restart. start one cycle after IDLE is reached → new job with identical sequence.
5. rst low at T0+12 → all outputs 0 immediately; no res_we/done afterward. A subsequent start yields a clean full job.
6. Golden check: bench with ROM contents and the datapath model accumulates ab_real/ab_imag gated by mac_valid/mac_first → matches software complex matrix product at every res_addr.
